effect_compressor: RTL

- Per-sample peak compressor/limiter stage in the effects chain.
- Sits directly downstream of the noise gate and consumes its o_data/o_valid pair.
- Tracks a peak envelope of the input. When the envelope exceeds a level-selected threshold, it scales the sample by threshold/envelope (infinite ratio), using a sequential divider and a multiplier.
- Same valid-pulse, enable/bypass and 3-bit level interface as the other effect stages.

---
 rtl/effect_compressor.sv | 102 ++++++++++
 1 files changed

// File: rtl/effect_compressor.sv
// effect_compressor: peak-envelope limiter scaling each sample by threshold/envelope
module effect_compressor #(
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_enable,
    input  logic [2:0]         i_level,
    input  logic signed [15:0] i_data,
    output logic signed [15:0] o_data,
    output logic               o_valid,
    output logic               o_ready
);
    typedef enum logic [1:0] {IDLE, DIV, MUL, OUT} state_t;
    state_t             state_q, state_d;
    logic [15:0]        env_q, env_d, q_q, q_d;
    logic signed [15:0] x_q, x_d, y_q, y_d, data_q, data_d;
    logic [31:0]        rem_q, rem_d, dsh_q, dsh_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [15:0]        thr, abs_x, env_next;
    logic signed [31:0] prod;
    logic               fits;
    assign thr      = (i_level == 3'd0) ? 16'd32767 : 16'h8000 >> i_level;
    assign abs_x    = (i_data == -16'sd32768) ? 16'd32767 : (i_data[15] ? 16'(-i_data) : 16'(i_data));
    assign env_next = (abs_x > env_q) ? env_q + ((abs_x - env_q) >> ATTACK_SHIFT)
                                      : env_q - ((env_q - abs_x) >> RELEASE_SHIFT);
    assign prod     = x_q * $signed(q_q);
    assign fits     = rem_q >= dsh_q;
    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_ready  = (state_q == IDLE);
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        x_d     = x_q;
        y_d     = y_q;
        rem_d   = rem_q;
        dsh_d   = dsh_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (i_valid) begin
                env_d   = env_next;
                x_d     = i_data;
                y_d     = i_data;
                rem_d   = {1'b0, thr, 15'd0};
                dsh_d   = {1'b0, env_next, 15'd0};
                q_d     = 16'd0;
                cnt_d   = 4'd0;
                state_d = (!i_enable || env_next <= thr) ? OUT : DIV;
            end
            // restoring division: compare against the divisor shifted down one place per cycle
            DIV: begin
                rem_d   = fits ? rem_q - dsh_q : rem_q;
                q_d     = {q_q[14:0], fits};
                dsh_d   = dsh_q >> 1;
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == 4'd15) ? MUL : DIV;
            end
            MUL: begin
                y_d     = 16'(prod >>> 15);
                state_d = OUT;
            end
            OUT: begin
                data_d  = y_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            env_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            rem_q   <= '0;
            dsh_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rem_q   <= rem_d;
            dsh_q   <= dsh_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
endmodule
